clk_divider_multi: RTL and testbench
====================================

# clk_divider_multi

Programmable multi-channel clock divider with 50% duty cycle for both even and odd divisors. It generalises the single fixed-N divider. NCH independent channels each divide the common `clk` by a runtime-loaded divisor. Divisor changes and enable/disable are glitch-free because they take effect only at period boundaries. The block sits at the clock-generation layer and feeds derived clocks or clock-enables to downstream blocks.

## Interface
- `NCH`, 4: number of output channels (1..16).
- `W`, 8: divisor width; legal divisor range 2..2^W-1.
- `DEF_DIV`, 2: divisor every channel holds after reset (2..2^W-1).
- `clk` input 1: sole clock. Posedge logic plus negedge half-cycle register for odd divisors.
- `rst` input 1: asynchronous, active-low reset.
- `ld_valid` input 1: divisor load request.
- `ld_ready` output 1: load can be accepted for channel `ld_ch`.
- `ld_ch` input clog2(NCH) (min 1): target channel.
- `ld_div` input W: new divisor.
- `ld_err` output 1: one-cycle pulse when an accepted load was rejected.
- `ch_en` input NCH: per-channel run enable.
- `clk_out` output NCH: divided clocks.
- `tick` output NCH: present only with `CLKDIV_TICK_EN`.

## Operation
- Each channel has the following state:
  - `run` flag.
  - Counter `cnt[W-1:0]`.
  - Active divisor `D`.
  - Pending divisor `P` with `pend` flag.
  - Posedge phase reg `A`.
  - Negedge reg `B`, which samples `A`.
- High count `H`: D/2 if D is even, (D+1)/2 if D is odd.
- `clk_out`:
  - Even D: `clk_out = A`.
  - Odd D: `clk_out = A & B`.
- Channel states:
  - IDLE: `run`=0, `cnt`=0, `A`=0.
    - At a posedge with `ch_en`=1: go to RUN with `cnt`<=0 and `A`<=1. If `pend` is set, D<=P and `pend`<=0 first.
  - RUN: `cnt` increments mod D. `A`<=(next cnt < H).
    - At wrap (cnt==D-1) with `ch_en`=0: go to IDLE, `A`<=0.
    - At wrap with `ch_en`=1: if `pend` is set, D<=P and `pend`<=0. Then `cnt`<=0 and `A`<=1.
- Load handshake:
  - `ld_ready` is combinational: !`pend[ld_ch]`. It is 1 when `ld_ch` ≥ NCH.
  - A transfer occurs at a posedge with `ld_valid` & `ld_ready`.
  - A valid transfer sets P<=`ld_div` and `pend`<=1.
  - An IDLE channel applies P at the next posedge regardless of `ch_en`.
- Rejection: a transfer with `ld_div` < 2 or `ld_ch` ≥ NCH changes no state. `ld_err` pulses high for the cycle after the transfer.
- Only one pending divisor per channel. A further load to that channel stalls (`ld_ready`=0) until P is applied.
- Disabling mid-period never truncates a pulse. The current period completes and the output stops low.

## Timing
- Reset values:
  - `clk_out`=0, `ld_err`=0, `tick`=0.
  - All `run`/`cnt`/`A`/`B`/`pend`=0.
  - D=DEF_DIV.
  - `ld_ready`=1.
- Reset is asynchronous. Asserting `rst` mid-operation forces `clk_out` low immediately and discards pending loads.
- Enable latency:
  - The posedge that samples `ch_en`=1 in IDLE raises `A`.
  - Even D: `clk_out` rises at that posedge.
  - Odd D: `clk_out` rises at the following negedge.
- Output waveform: period exactly D clk cycles. High time D/2 cycles, including 2.5 cycles for D=5.
- Load-to-effect:
  - RUN channel: first posedge with cnt 0 after the current period ends.
  - IDLE channel: 1 cycle.
- Simultaneous load and wrap on the same channel: a load arriving when `pend`=0 in the wrap cycle is accepted and held. It applies at the next wrap, not the current one.

## Configuration
- `CLKDIV_TICK_EN` defined:
  - Adds `tick[NCH]` output.
  - `tick[i]` is 1 for exactly one clk cycle whenever channel i is in RUN with cnt==0, i.e. the first cycle of each output period.
  - Reset value is 0.
- Undefined: the `tick` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then `ch_en`=0001, DEF_DIV=2, 10 ns clk -> `clk_out[0]`: 20 ns period, 10/10 ns. Channels 1..3 stay 0.
- Load ch1 D=5, then `ch_en[1]`=1 -> `clk_out[1]`: 50 ns period, 25 ns high and 25 ns low, rising on a negedge.
- With ch0 running D=2, load ch0 D=6 and immediately attempt a second load to ch0:
  - `ld_ready`=0 until the wrap.
  - Current period finishes at 20 ns.
  - Then 30/30 ns.
- Load `ld_div`=1, then load `ld_ch`=4 -> `ld_err` pulses one cycle each. No channel's period changes.
- Deassert `ch_en[1]` mid-high with D=5 -> pulse completes at 25 ns high. Output stays low. Reassert -> rises within 1 cycle, 50 ns period.
- Pull `rst` low mid-pulse -> all `clk_out` low immediately. After release, divisors are DEF_DIV. With `CLKDIV_TICK_EN`, check `tick` one pulse per period.

Source files
------------

// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - multi-channel programmable 50% duty clock divider
// Optional CLKDIV_TICK_EN adds a per-channel period-start tick output.
module clk_divider_multi #(
  parameter int NCH     = 4,
  parameter int W       = 8,
  parameter int DEF_DIV = 2,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [CHW-1:0]   ld_ch,
  input  logic [W-1:0]     ld_div,
  output logic             ld_err,
  input  logic [NCH-1:0]   ch_en,
`ifdef CLKDIV_TICK_EN
  output logic [NCH-1:0]   tick,
`endif
  output logic [NCH-1:0]   clk_out
);

  localparam logic [CHW:0] NCH_V = (CHW+1)'(NCH);

  logic [NCH-1:0] run;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] a;
  logic [NCH-1:0] b;
  logic [W-1:0]   cnt [NCH];
  logic [W-1:0]   d   [NCH];
  logic [W-1:0]   p   [NCH];
  logic [W-1:0]   h   [NCH];

  logic ch_bad;
  logic div_bad;
  logic xfer;

  assign ch_bad  = ({1'b0, ld_ch} >= NCH_V);
  assign div_bad = (ld_div < W'(2));
  assign xfer    = ld_valid & ld_ready;

  always_comb begin
    ld_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (ld_ch == CHW'(i)) ld_ready = !pend[i];
    end
  end

  // High count: ceil(D/2), so odd divisors hold A one extra cycle that B trims by half.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      h[i] = (d[i] >> 1) + {{(W-1){1'b0}}, d[i][0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_err <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        run[i]  <= 1'b0;
        pend[i] <= 1'b0;
        a[i]    <= 1'b0;
        cnt[i]  <= '0;
        d[i]    <= W'(DEF_DIV);
        p[i]    <= '0;
      end
    end else begin
      ld_err <= xfer & (ch_bad | div_bad);
      for (int i = 0; i < NCH; i++) begin
        if (!run[i]) begin
          cnt[i] <= '0;
          if (pend[i]) begin
            d[i]    <= p[i];
            pend[i] <= 1'b0;
          end
          if (ch_en[i]) begin
            run[i] <= 1'b1;
            a[i]   <= 1'b1;
          end
        end else if (cnt[i] == d[i] - W'(1)) begin
          // Period boundary: the only point where divisor or enable may change.
          cnt[i] <= '0;
          if (ch_en[i]) begin
            a[i] <= 1'b1;
            if (pend[i]) begin
              d[i]    <= p[i];
              pend[i] <= 1'b0;
            end
          end else begin
            run[i] <= 1'b0;
            a[i]   <= 1'b0;
          end
        end else begin
          cnt[i] <= cnt[i] + W'(1);
          a[i]   <= ((cnt[i] + W'(1)) < h[i]);
        end
        if (xfer && !ch_bad && !div_bad && (ld_ch == CHW'(i))) begin
          p[i]    <= ld_div;
          pend[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      b <= '0;
    end else begin
      b <= a;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      clk_out[i] = d[i][0] ? (a[i] & b[i]) : a[i];
    end
  end

`ifdef CLKDIV_TICK_EN
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tick[i] = run[i] & (cnt[i] == '0);
    end
  end
`endif

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - bench for clk_divider_multi against a period-level model
module tb_clk_divider_multi;
  localparam int NCH     = 6;
  localparam int W       = 8;
  localparam int DEF_DIV = 2;
  localparam int CHW     = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ld_valid = 1'b0;
  logic [CHW-1:0] ld_ch = '0;
  logic [W-1:0]   ld_div = '0;
  logic [NCH-1:0] ch_en = '0;
  wire            ld_ready;
  wire            ld_err;
  wire  [NCH-1:0] clk_out;
`ifdef CLKDIV_TICK_EN
  wire  [NCH-1:0] tick;
`endif

  int tests = 0;
  int fails = 0;
  int n = 0;
  int j;
  int m_run [NCH];
  int m_start [NCH];
  int m_d [NCH];
  int m_p [NCH];
  int m_pend [NCH];
  bit m_err;

  clk_divider_multi #(.NCH(NCH), .W(W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_ch(ld_ch),
    .ld_div(ld_div),
    .ld_err(ld_err),
    .ch_en(ch_en),
`ifdef CLKDIV_TICK_EN
    .tick(tick),
`endif
    .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_start[i] = 0; m_d[i] = DEF_DIV; m_p[i] = 0; m_pend[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit exp_ready();
    if (int'(ld_ch) >= NCH) return 1'b1;
    return (m_pend[ld_ch] == 0);
  endfunction

  // Period-level view: a running channel started its current period at posedge m_start.
  function automatic void model_edge();
    bit xfer;
    bit bad;
    xfer = ld_valid && exp_ready();
    bad  = (int'(ld_div) < 2) || (int'(ld_ch) >= NCH);
    n++;
    for (int i = 0; i < NCH; i++) begin
      if (m_run[i] != 0) begin
        if (n == m_start[i] + m_d[i]) begin
          if (ch_en[i]) begin
            if (m_pend[i] != 0) begin m_d[i] = m_p[i]; m_pend[i] = 0; end
            m_start[i] = n;
          end else begin
            m_run[i] = 0;
          end
        end
      end else begin
        if (m_pend[i] != 0) begin m_d[i] = m_p[i]; m_pend[i] = 0; end
        if (ch_en[i]) begin m_run[i] = 1; m_start[i] = n; end
      end
    end
    m_err = xfer && bad;
    if (xfer && !bad) begin
      m_p[ld_ch] = int'(ld_div);
      m_pend[ld_ch] = 1;
    end
  endfunction

  function automatic logic [NCH-1:0] exp_out(input int hh);
    logic [NCH-1:0] r;
    int k;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      if (m_run[i] != 0) begin
        k = 2 * (n - m_start[i]) + hh;
        if (m_d[i] % 2 == 0) r[i] = (k < m_d[i]);
        else                 r[i] = (k >= 1) && (k <= m_d[i]);
      end
    end
    return r;
  endfunction

`ifdef CLKDIV_TICK_EN
  function automatic logic [NCH-1:0] exp_tick();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (m_run[i] != 0) && (n == m_start[i]);
    return r;
  endfunction
`endif

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("clk_out_hi_half", 32'(clk_out), 32'(exp_out(0)));
    chk("ld_err", 32'(ld_err), 32'(m_err));
    chk("ld_ready_post_edge", 32'(ld_ready), 32'(exp_ready()));
`ifdef CLKDIV_TICK_EN
    chk("tick", 32'(tick), 32'(exp_tick()));
`endif
    @(negedge clk);
    #1;
    chk("clk_out_lo_half", 32'(clk_out), 32'(exp_out(1)));
  endtask

  task automatic load(input int ch, input int dv);
    ld_valid = 1'b1;
    ld_ch = CHW'(ch);
    ld_div = W'(dv);
    #1;
    chk("ld_ready_on_drive", 32'(ld_ready), 32'(exp_ready()));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_clk_out", 32'(clk_out), 32'd0);
    chk("reset_ld_err", 32'(ld_err), 32'd0);
    chk("reset_ld_ready", 32'(ld_ready), 32'd1);
`ifdef CLKDIV_TICK_EN
    chk("reset_tick", 32'(tick), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    ch_en = 6'b000001;
    repeat (10) step();

    load(1, 5);
    step();
    ld_valid = 1'b0;
    step();
    ch_en = 6'b000011;
    repeat (20) step();

    load(0, 6);
    step();
    load(0, 4);
    repeat (8) step();
    ld_valid = 1'b0;
    repeat (20) step();

    load(2, 1);
    step();
    load(6, 3);
    step();
    load(7, 9);
    step();
    ld_valid = 1'b0;
    repeat (10) step();

    ch_en[1] = 1'b0;
    repeat (12) step();
    ch_en[1] = 1'b1;
    repeat (15) step();

    for (int c = 0; c < 1500; c++) begin
      ld_valid = ($urandom_range(0, 3) == 0);
      ld_ch = CHW'($urandom_range(0, 7));
      ld_div = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 1)) : W'($urandom_range(2, 9));
      if ($urandom_range(0, 15) == 0) begin
        j = int'($urandom_range(0, NCH - 1));
        ch_en[j] = ~ch_en[j];
      end
      step();
    end

    ld_valid = 1'b0;
    ch_en = '1;
    repeat (12) step();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_clk_out", 32'(clk_out), 32'd0);
    chk("async_reset_ld_ready", 32'(ld_ready), 32'd1);
    chk("async_reset_ld_err", 32'(ld_err), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
